addsub_accumulator: RTL
=======================

# addsub_accumulator

Sequencing stage placed directly upstream of the 32-bit adder-subtractor. It accepts a valid/ready stream of signed 32-bit operands with per-beat add/sub opcodes and drives the adder's A/B/sel inputs from an internal accumulator. It captures the adder sum back into the accumulator, tracks two's-complement overflow, and presents one result per burst (terminated by `in_last`) on a valid/ready output.

## Interface
- `CNT_W`, default 8: width of the beat counter.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous reset, active-high.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  block can accept a beat.
- `in_data`  in  32  signed operand (two's complement).
- `in_op`  in  1  0 = add, 1 = subtract (acc − in_data).
- `in_clear`  in  1  beat starts from 0 instead of the current accumulator.
- `in_last`  in  1  final beat of the burst.
- `add_a`  out  32  adder A operand; combinational.
- `add_b`  out  32  adder B operand; combinational.
- `add_sel`  out  1  adder sel; combinational.
- `add_s`  in  32  adder result; combinational return from the adder-subtractor.
- `out_valid`  out  1  burst result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  32  final accumulator value.
- `out_ovf`  out  1  sticky overflow seen during the burst.
- `out_count`  out  CNT_W  beats accepted in the burst.

## Operation
- Two states:
  - ACCUM: `in_ready` = 1, `out_valid` = 0.
  - DONE: `in_ready` = 0, `out_valid` = 1.
- Adder drive, at all times:
  - `add_a` = `in_clear` ? 0 : acc.
  - `add_b` = `in_data`.
  - `add_sel` = `in_op`.
- Beat accept (ACCUM and `in_valid`):
  - acc <= `add_s`, or the saturated value (see Configuration).
  - ovf <= ovf | beat_ovf.
  - count <= count + 1, saturating at all-ones.
  - If `in_last`, go to DONE.
- beat_ovf is computed from `add_a`, `add_b`, `add_s`:
  - add: a[31] == b[31] and s[31] != a[31].
  - sub: a[31] != b[31] and s[31] != a[31].
- `in_clear` affects only the accepted beat. It does not reset ovf or count.
- DONE:
  - `out_data` = acc, `out_ovf` = ovf, `out_count` = count, held stable while `out_ready` = 0.
  - On `out_ready`: acc, ovf and count are zeroed and the state returns to ACCUM.
- Outputs `out_data`, `out_ovf` and `out_count` track the live registers in ACCUM too. They are qualified only by `out_valid`.
- An `in_valid` pulse while in DONE is not accepted; the producer holds the beat.

## Timing
- Reset values:
  - state = ACCUM.
  - acc = 0x00000000.
  - `out_valid` = 0, `out_ovf` = 0, `out_count` = 0, `out_data` = 0.
  - `in_ready` = 1 from the first cycle after reset.
- Throughput: one beat per cycle in ACCUM.
- Latency: `out_valid` rises the cycle after the `in_last` beat is accepted.
- Minimum burst turnaround: a new beat can be accepted the cycle after the `out_ready` handshake. There is no bubble beyond the DONE cycle(s).
- `rst` asserted mid-burst or in DONE discards all state. There is no output for the partial burst.
- `rst` has priority over every handshake in the same cycle.
- A single-beat burst (`in_last` on the first beat) is legal and yields count = 1.
- The `add_*` outputs are combinational from acc and the `in_*` inputs. The accept path is one combinational loop through the adder; there is no registered adder stage.

## Configuration
- `ADDSUB_SATURATE_EN` defined:
  - On beat_ovf, acc is loaded with 0x7FFFFFFF if the true result is positive (a[31] = 0), else 0x80000000.
  - ovf is still set.
- `ADDSUB_SATURATE_EN` undefined:
  - acc is loaded with `add_s` unchanged (wrap-around).
  - ovf is still set.

## Test plan
- Reset, then burst {clear+add 5, add 7, sub 2 with last} -> one cycle later `out_valid` = 1, `out_data` = 0x0000000A, `out_ovf` = 0, `out_count` = 3.
- Burst {clear+add 0x7FFFFFFF, add 1 last} -> `out_ovf` = 1.
  - `out_data` = 0x80000000 without the macro.
  - `out_data` = 0x7FFFFFFF with `ADDSUB_SATURATE_EN`.
- Burst {clear+add 0x80000000, sub 1 last} -> `out_ovf` = 1.
  - `out_data` = 0x7FFFFFFF without the macro.
  - `out_data` = 0x80000000 with the macro.
- Hold `out_ready` = 0 for 5 cycles in DONE with `in_valid` = 1 -> `in_ready` = 0 and outputs stable. Then assert `out_ready` -> next cycle the new beat is accepted, counting from acc = 0.
- Assert `rst` after 2 accepted beats of a burst -> no `out_valid`; acc = 0, count = 0, state ACCUM on the next cycle.
- 300 single add-1 beats with `CNT_W` = 8 -> `out_count` = 255 (saturated), `out_data` = 300.

Source files
------------

// File: rtl/addsub_accumulator.sv
// Sequencing stage in front of a 32-bit adder-subtractor: accumulates a burst of operand beats and emits one result per burst.
// Optional feature macro: ADDSUB_SATURATE_EN (clamp the accumulator on overflow instead of wrapping).
module addsub_accumulator #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_op,
    input  logic             in_clear,
    input  logic             in_last,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    output logic             add_sel,
    input  logic [31:0]      add_s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_count,
    output logic             dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // a producer holding valid keeps its payload stable until that edge, and ready never depends on valid.

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [31:0]       acc;
    logic              ovf;
    logic [CNT_W-1:0]  count;
    logic              accept;
    logic              drain;
    logic              beat_ovf;
    logic [31:0]       acc_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ACCUM;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;
    assign dbg_state = (state == DONE);

    // The adder sits outside this block; its sum returns combinationally on add_s.
    assign add_a   = in_clear ? 32'h0000_0000 : acc;
    assign add_b   = in_data;
    assign add_sel = in_op;

    always_comb begin
        if (add_sel) begin
            beat_ovf = (add_a[31] != add_b[31]) && (add_s[31] != add_a[31]);
        end else begin
            beat_ovf = (add_a[31] == add_b[31]) && (add_s[31] != add_a[31]);
        end
    end

`ifdef ADDSUB_SATURATE_EN
    // On overflow the true result has the sign of add_a, so clamp toward that sign.
    assign acc_load = beat_ovf ? (add_a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : add_s;
`else
    assign acc_load = add_s;
`endif

    always_ff @(posedge clk) begin
        if (rst || drain) begin
            acc   <= '0;
            ovf   <= 1'b0;
            count <= '0;
        end else if (accept) begin
            acc <= acc_load;
            ovf <= ovf | beat_ovf;
            if (count != '1) begin
                count <= count + CNT_W'(1);
            end
        end
    end

    assign out_data  = acc;
    assign out_ovf   = ovf;
    assign out_count = count;

endmodule
